// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
// Shared definitions for the multi-cycle control unit:
//   - state_e   : FSM state encoding (also exported on state_o)
//   - cls_e     : instruction class produced by the decoder
//   - OP_*      : RV32 major opcodes understood by the core
//   - ALU_*     : ALU function codes used by the controller itself
//   - WB_*, SRCA_*, SRCB_*, PCSEL_*, ADDR_* : datapath mux encodings
//   - branch_taken() : BEQ/BNE resolution from the ALU zero flag
// -----------------------------------------------------------------------------
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_I      = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JAL    = 3'd6
  } cls_e;

  // RV32 major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Branch funct3 values supported by the core
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  // Shift-right funct3: the only I-type op where funct7[5] selects the function
  localparam logic [2:0] F3_SR  = 3'b101;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Write-back source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // ALU operand selects
  localparam logic       SRCA_RS1  = 1'b0;
  localparam logic       SRCA_PC   = 1'b1;
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // PC source and memory address selects
  localparam logic PCSEL_PC4 = 1'b0;
  localparam logic PCSEL_ALU = 1'b1;
  localparam logic ADDR_PC   = 1'b0;
  localparam logic ADDR_ALU  = 1'b1;

  // BEQ takes on zero, BNE (funct3[0]=1) takes on non-zero
  function automatic logic branch_taken(input logic zero, input logic funct3_0);
    return zero ^ funct3_0;
  endfunction

endpackage

// File: rtl/multicycle_decode.sv
// -----------------------------------------------------------------------------
// multicycle_decode
// Purely combinational instruction classifier for the multi-cycle controller.
// Ports:
//   i_opcode  [6:0] : IR[6:0]
//   i_funct3  [2:0] : IR[14:12], used to reject unsupported branch kinds
//   o_cls           : instruction class (CLS_NONE when illegal)
//   o_illegal       : opcode (or branch funct3) not supported by the core
// -----------------------------------------------------------------------------
module multicycle_decode
  import multicycle_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output cls_e       o_cls,
  output logic       o_illegal
);

  // Opcode to class lookup; anything outside the supported set is illegal
  always_comb begin
    o_cls     = CLS_NONE;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R:     o_cls = CLS_R;
      OP_I:     o_cls = CLS_I;
      OP_LOAD:  o_cls = CLS_LOAD;
      OP_STORE: o_cls = CLS_STORE;
      OP_JAL:   o_cls = CLS_JAL;
      OP_BRANCH: begin
        // Only BEQ/BNE are implemented; other compares have no datapath support
        if ((i_funct3 == F3_BEQ) || (i_funct3 == F3_BNE)) begin
          o_cls = CLS_BRANCH;
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control FSM (FETCH, DECODE, EXEC, MEM, WB, HALT) that sequences
// the PC/register-file/ALU datapath and owns the single shared memory port.
//
// Parameters:
//   MEM_TIMEOUT : cycles to wait for mem_ready before flagging bus_err (>=2)
//   ALUOP_W     : width of alu_op
//
// Ports:
//   clk, reset                 : rising-edge clock, async active-high reset
//   opcode/funct3/funct7_5     : instruction fields from IR
//   alu_zero                   : ALU result == 0 (branch compare)
//   mem_ready                  : memory completes the current request
//   ir_we, pc_we, pc_sel       : IR load, PC update and PC source select
//   rf_we, wb_sel              : register write and write-back source
//   alu_src_a, alu_src_b       : ALU operand selects
//   alu_op                     : ALU function
//   mem_req, mem_we, mem_addr_sel : shared memory port request
//   state_o                    : current state (debug)
//   illegal, bus_err           : sticky error flags, cleared only by reset
//
// Optional feature (macro MULTICYCLE_PERF_EN):
//   adds instret[31:0] (completed fetch handshakes) and cycles[31:0]
//   (cycles outside HALT); both wrap and reset to 0.
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALUOP_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               ir_we,
  output logic               pc_we,
  output logic               pc_sel,
  output logic               rf_we,
  output logic [1:0]         wb_sel,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic [2:0]         state_o,
  output logic               illegal,
  output logic               bus_err
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0]        instret,
  output logic [31:0]        cycles
`endif
);

  localparam int               CNT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e             r_state;
  state_e             w_state_next;
  cls_e               r_cls;
  cls_e               w_dec_cls;
  logic               w_dec_illegal;
  logic               r_taken;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_illegal;
  logic               r_bus_err;

  logic               w_set_illegal;
  logic               w_set_bus_err;
  logic               w_wait_inc;

  logic               w_ir_we;
  logic               w_pc_we;
  logic               w_pc_sel;
  logic               w_rf_we;
  logic [1:0]         w_wb_sel;
  logic               w_alu_src_a;
  logic [1:0]         w_alu_src_b;
  logic [ALUOP_W-1:0] w_alu_op;
  logic               w_mem_req;
  logic               w_mem_we;
  logic               w_mem_addr_sel;

  multicycle_decode u_decode (
    .i_opcode  (opcode),
    .i_funct3  (funct3),
    .o_cls     (w_dec_cls),
    .o_illegal (w_dec_illegal)
  );

  // Next-state and datapath control decode
  always_comb begin
    w_state_next   = r_state;
    w_set_illegal  = 1'b0;
    w_set_bus_err  = 1'b0;
    w_wait_inc     = 1'b0;
    w_ir_we        = 1'b0;
    w_pc_we        = 1'b0;
    w_pc_sel       = PCSEL_PC4;
    w_rf_we        = 1'b0;
    w_wb_sel       = WB_ALU;
    w_alu_src_a    = SRCA_RS1;
    w_alu_src_b    = SRCB_RS2;
    w_alu_op       = ALUOP_W'(ALU_ADD);
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = ADDR_PC;
    // Reset forces every strobe low immediately, so a request in flight
    // is withdrawn without waiting for a clock edge.
    if (reset) begin
      w_state_next = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          w_mem_req = 1'b1;
          if (mem_ready) begin
            w_ir_we      = 1'b1;
            w_pc_we      = 1'b1;
            w_state_next = ST_DECODE;
          end else if (r_wait_cnt == CNT_LAST) begin
            w_set_bus_err = 1'b1;
            w_state_next  = ST_HALT;
          end else begin
            w_wait_inc = 1'b1;
          end
        end

        ST_DECODE: begin
          if (w_dec_illegal) begin
            w_set_illegal = 1'b1;
            w_state_next  = ST_HALT;
          end else begin
            w_state_next = ST_EXEC;
          end
        end

        ST_EXEC: begin
          case (r_cls)
            CLS_R: begin
              w_alu_src_b  = SRCB_RS2;
              w_alu_op     = ALUOP_W'({funct7_5, funct3});
              w_state_next = ST_WB;
            end
            CLS_I: begin
              // funct7[5] only distinguishes SRLI/SRAI; elsewhere it is imm bits
              w_alu_src_b  = SRCB_IMM;
              w_alu_op     = ALUOP_W'({(funct3 == F3_SR) ? funct7_5 : 1'b0, funct3});
              w_state_next = ST_WB;
            end
            CLS_LOAD, CLS_STORE: begin
              w_alu_src_b  = SRCB_IMM;
              w_alu_op     = ALUOP_W'(ALU_ADD);
              w_state_next = ST_MEM;
            end
            CLS_BRANCH: begin
              w_alu_src_a  = SRCA_RS1;
              w_alu_src_b  = SRCB_RS2;
              w_alu_op     = ALUOP_W'(ALU_SUB);
              w_state_next = ST_WB;
            end
            CLS_JAL: begin
              w_alu_src_a  = SRCA_PC;
              w_alu_src_b  = SRCB_IMM;
              w_alu_op     = ALUOP_W'(ALU_ADD);
              w_state_next = ST_WB;
            end
            default: begin
              w_set_illegal = 1'b1;
              w_state_next  = ST_HALT;
            end
          endcase
        end

        ST_MEM: begin
          w_mem_req      = 1'b1;
          w_mem_addr_sel = ADDR_ALU;
          w_mem_we       = (r_cls == CLS_STORE);
          if (mem_ready) begin
            w_state_next = (r_cls == CLS_STORE) ? ST_FETCH : ST_WB;
          end else if (r_wait_cnt == CNT_LAST) begin
            w_set_bus_err = 1'b1;
            w_state_next  = ST_HALT;
          end else begin
            w_wait_inc = 1'b1;
          end
        end

        ST_WB: begin
          w_state_next = ST_FETCH;
          case (r_cls)
            CLS_R, CLS_I: begin
              w_rf_we  = 1'b1;
              w_wb_sel = WB_ALU;
            end
            CLS_LOAD: begin
              w_rf_we  = 1'b1;
              w_wb_sel = WB_MEM;
            end
            CLS_JAL: begin
              // Keep the ALU on PC+imm so the jump target is still presented
              w_rf_we     = 1'b1;
              w_wb_sel    = WB_PC4;
              w_pc_we     = 1'b1;
              w_pc_sel    = PCSEL_ALU;
              w_alu_src_a = SRCA_PC;
              w_alu_src_b = SRCB_IMM;
              w_alu_op    = ALUOP_W'(ALU_ADD);
            end
            CLS_BRANCH: begin
              // Target = oldpc + imm, computed here after the compare in EXEC
              w_pc_we     = r_taken;
              w_pc_sel    = r_taken ? PCSEL_ALU : PCSEL_PC4;
              w_alu_src_a = r_taken ? SRCA_PC : SRCA_RS1;
              w_alu_src_b = r_taken ? SRCB_IMM : SRCB_RS2;
              w_alu_op    = ALUOP_W'(ALU_ADD);
            end
            default: begin
              w_set_illegal = 1'b1;
              w_state_next  = ST_HALT;
            end
          endcase
        end

        ST_HALT: begin
          w_state_next = ST_HALT;
        end

        // Unused encodings are treated as a fault and parked in HALT
        default: begin
          w_state_next = ST_HALT;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Memory wait counter: cleared whenever a state is (re)entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_wait_cnt <= '0;
    end else if (w_wait_inc) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Instruction class captured in DECODE for use in later states
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cls <= CLS_NONE;
    end else if (r_state == ST_DECODE) begin
      r_cls <= w_dec_cls;
    end else begin
      r_cls <= r_cls;
    end
  end

  // Branch outcome sampled while the ALU compares rs1-rs2 in EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_taken <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_taken <= branch_taken(alu_zero, funct3[0]);
    end else begin
      r_taken <= r_taken;
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_illegal <= r_illegal | w_set_illegal;
      r_bus_err <= r_bus_err | w_set_bus_err;
    end
  end

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] r_instret;
  logic [31:0] r_cycles;

  // Performance counters: fetch handshakes and non-halted cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret <= 32'd0;
      r_cycles  <= 32'd0;
    end else begin
      r_instret <= ((r_state == ST_FETCH) && mem_ready) ? (r_instret + 32'd1) : r_instret;
      r_cycles  <= (r_state != ST_HALT) ? (r_cycles + 32'd1) : r_cycles;
    end
  end

  assign instret = r_instret;
  assign cycles  = r_cycles;
`endif

  assign ir_we        = w_ir_we;
  assign pc_we        = w_pc_we;
  assign pc_sel       = w_pc_sel;
  assign rf_we        = w_rf_we;
  assign wb_sel       = w_wb_sel;
  assign alu_src_a    = w_alu_src_a;
  assign alu_src_b    = w_alu_src_b;
  assign alu_op       = w_alu_op;
  assign mem_req      = w_mem_req;
  assign mem_we       = w_mem_we;
  assign mem_addr_sel = w_mem_addr_sel;
  assign state_o      = r_state;
  assign illegal      = r_illegal;
  assign bus_err      = r_bus_err;

endmodule
